// File: rtl/sc_neuron_pe.sv
// Stochastic-computing neuron PE: N_IN AND-multiplied bitstream channels plus a bias,
// counted over one 255-cycle LFSR period, then a shift/slope saturating activation.
module sc_neuron_pe #(
  parameter int          N_IN   = 4,
  parameter logic [7:0]  SEED_X = 8'h01,
  parameter logic [7:0]  SEED_W = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*N_IN-1:0]   w,
  input  logic [8*N_IN-1:0]   x,
  input  logic [7:0]          b,
  input  logic [2:0]          shif,
  input  logic [2:0]          slope,
  output logic                busy,
  output logic                done,
  output logic [7:0]          y
);

  localparam int ACC_W = $clog2((N_IN + 1) * 255 + 1);
  localparam int PRD_W = ACC_W + 3;
  localparam int INC_W = $clog2(N_IN + 2);

  typedef enum logic [1:0] {IDLE, RUN, ACT} state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [7:0]          cnt;
  logic [7:0]          lfsr_x;
  logic [7:0]          lfsr_w;
  logic [8*N_IN-1:0]   w_q;
  logic [8*N_IN-1:0]   x_q;
  logic [7:0]          b_q;
  logic [2:0]          shif_q;
  logic [2:0]          slope_q;

  logic [INC_W-1:0]    inc;
  logic [PRD_W-1:0]    prod;
  logic [PRD_W-1:0]    scaled;

  // x^8+x^6+x^5+x^4+1, maximal length: never reaches zero from a nonzero seed
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [7:0] sat8(input logic [PRD_W-1:0] v);
    return (v > PRD_W'(255)) ? 8'hFF : v[7:0];
  endfunction

  always_comb begin
    inc = '0;
    for (int i = 0; i < N_IN; i++) begin
      inc = inc + INC_W'((x_q[8*i +: 8] >= lfsr_x) && (w_q[8*i +: 8] >= lfsr_w));
    end
    inc    = inc + INC_W'(b_q >= lfsr_x);
    prod   = PRD_W'(acc) * PRD_W'(slope_q);
    scaled = prod >> shif_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= '0;
      acc     <= '0;
      cnt     <= '0;
      lfsr_x  <= SEED_X;
      lfsr_w  <= SEED_W;
      w_q     <= '0;
      x_q     <= '0;
      b_q     <= '0;
      shif_q  <= '0;
      slope_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_q     <= w;
            x_q     <= x;
            b_q     <= b;
            shif_q  <= shif;
            slope_q <= slope;
            lfsr_x  <= SEED_X;
            lfsr_w  <= SEED_W;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc    <= acc + ACC_W'(inc);
          lfsr_x <= lfsr_next(lfsr_x);
          lfsr_w <= lfsr_next(lfsr_w);
          cnt    <= cnt + 8'd1;
          if (cnt == 8'd254) state <= ACT;
        end
        ACT: begin
          y     <= sat8(scaled);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_neuron_pe.sv
// Directed bench for sc_neuron_pe: vector table plus hand-written sequences for
// restart attempts, start on the ACT edge and mid-run reset.
module tb_sc_neuron_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] w = '0;
  logic [31:0] x = '0;
  logic [7:0]  b = '0;
  logic [2:0]  shif = '0;
  logic [2:0]  slope = '0;
  logic        busy;
  logic        done;
  logic [7:0]  y;

  int tests = 0;
  int fails = 0;

  sc_neuron_pe #(.N_IN(4), .SEED_X(8'h01), .SEED_W(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w(w), .x(x), .b(b),
    .shif(shif), .slope(slope), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] x;
    logic [7:0]  b;
    logic [2:0]  shif;
    logic [2:0]  slope;
    logic [7:0]  exp_y;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_ops(input vec_t v);
    w = v.w; x = v.x; b = v.b; shif = v.shif; slope = v.slope;
  endtask

  // Drive start for one edge; returns #1 after the accepting edge k.
  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    set_ops(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int early;
    early = 0;
    pulse_start(v);
    check({nm, " busy after start"}, busy, 1);
    for (int e = 1; e <= 256; e++) begin
      @(posedge clk);
      #1;
      if (e < 256 && done) early++;
    end
    check({nm, " early done"}, early, 0);
    check({nm, " done at k+256"}, done, 1);
    check({nm, " busy at k+256"}, busy, 0);
    check({nm, " y"}, y, v.exp_y);
    check({nm, " lfsr_x back to seed"}, dut.lfsr_x, 8'h01);
    check({nm, " lfsr_w back to seed"}, dut.lfsr_w, 8'hA5);
    @(posedge clk);
    #1;
    check({nm, " done cleared"}, done, 0);
  endtask

  initial begin
    int ndone;
    int waited;
    vec_t alt;

    vecs[0] = '{32'hFFFFFFFF, 32'h3F3F3F3F, 8'h3F, 3'd3, 3'd2, 8'd78};
    vecs[1] = '{32'h00000000, 32'hC8C8C8C8, 8'd100, 3'd0, 3'd1, 8'd100};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 3'd7, 3'd7, 8'd69};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 3'd0, 3'd7, 8'd255};
    vecs[4] = '{32'h281E140A, 32'hFFFFFFFF, 8'h00, 3'd1, 3'd3, 8'd150};
    vecs[5] = '{32'hFFFFFFFF, 32'h04030201, 8'h05, 3'd0, 3'd7, 8'd105};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 3'd2, 3'd0, 8'd0};

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset y", y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle without start", busy, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Restart attempts during RUN with x changed: one done, original result.
    pulse_start(vecs[0]);
    ndone = 0;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (e == 10)  begin x = 32'hFFFFFFFF; start = 1'b1; end
      if (e == 11)  start = 1'b0;
      if (e == 254) start = 1'b1;
      if (e == 255) start = 1'b0;
    end
    check("restart ignored done count", ndone, 1);
    check("restart ignored y", y, 78);

    // Start held across the ACT edge: accepted only on the following IDLE edge.
    pulse_start(vecs[0]);
    for (int e = 1; e <= 255; e++) begin
      @(posedge clk);
      #1;
    end
    set_ops(vecs[1]);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("act edge done", done, 1);
    check("act edge busy", busy, 0);
    check("act edge y", y, 78);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("next idle accepts busy", busy, 1);
    check("next idle done low", done, 0);
    waited = 0;
    while (!done && waited < 400) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("second run latency", waited, 256);
    check("second run y", y, 100);

    // Reset at RUN cycle 100: everything back to reset values, no done.
    pulse_start(vecs[2]);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset busy", busy, 0);
    check("midrun reset y", y, 0);
    check("midrun reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int e = 0; e < 300; e++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    check("no activity after reset", ndone, 0);
    alt = vecs[0];
    run_vec(alt, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
